seq_divider_64: RTL and testbench
=================================

SEQ_DIVIDER_64 -- requirements
Module: seq_divider_64

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width; only 64 is supported and verified.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port is_signed  input  1  1 = two's-complement divide, 0 = unsigned.
REQ-006 SHALL have port dividend  input  64  numerator; sampled with start.
REQ-007 SHALL have port divisor  input  64  denominator; sampled with start.
REQ-008 SHALL have port busy  output  1  high from the accepting edge until done.
REQ-009 SHALL have port done  output  1  single-cycle pulse; results valid.
REQ-010 SHALL have port quotient  output  64  result quotient.
REQ-011 SHALL have port remainder  output  64  result remainder.
REQ-012 SHALL have port div_by_zero  output  1  divisor was zero; valid with done, held with results.

Function
REQ-013 SHALL implement FSM states IDLE, DIVIDE, FIX, DONE.
REQ-014 IDLE: start=1 at edge E0 -> capture operands and is_signed; busy=1; go to DIVIDE, or to FIX if divisor==0.
REQ-015 Signed mode: latch |dividend|, |divisor|, neg_q = sign(dividend) XOR sign(divisor), neg_r = sign(dividend).
REQ-016 DIVIDE: restoring shift-subtract, one quotient bit per cycle, MSB first; 6-bit counter; exactly 64 cycles.
REQ-017 Per iteration: partial remainder (65-bit) = {rem, next dividend bit}; if >= divisor, subtract and set quotient bit = 1, else bit = 0.
REQ-018 FIX: one cycle; negate quotient if neg_q, negate remainder if neg_r (signed mode only); load quotient/remainder outputs.
REQ-019 DONE: done=1, busy=0 for exactly one cycle; next state IDLE.
REQ-020 Normal latency: done high in the cycle after edge E0+66; divide-by-zero latency: done after edge E0+2.
REQ-021 Divide by zero: quotient = 0xFFFF_FFFF_FFFF_FFFF, remainder = dividend (unmodified), div_by_zero=1; both modes.
REQ-022 Signed overflow (0x8000_0000_0000_0000 / -1): quotient = 0x8000_0000_0000_0000, remainder = 0, div_by_zero=0; no special flag.
REQ-023 Identities: dividend = quotient*divisor + remainder (mod 2^64); |remainder| < |divisor|; remainder sign = dividend sign or zero.
REQ-024 start while busy (DIVIDE/FIX/DONE): ignored; no re-capture; operand changes after E0 have no effect.
REQ-025 quotient, remainder, div_by_zero SHALL hold their values from DONE until the FIX cycle of the next operation.
REQ-026 start asserted in the cycle done=1 is ignored; accepted one cycle later in IDLE.

Reset
REQ-027 rst_n=0 at any edge, including mid-DIVIDE: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
REQ-028 Reset SHALL take priority over start in the same cycle; no operation is accepted.

Verification
REQ-029 Unsigned 100 / 7 -> quotient=14, remainder=2, div_by_zero=0; done after edge E0+66; busy high for 66 cycles.
REQ-030 Signed -100 / 7 -> quotient=0xFFFF_FFFF_FFFF_FFF2 (-14), remainder=0xFFFF_FFFF_FFFF_FFFE (-2); signed 100 / -7 -> quotient=-14, remainder=2.
REQ-031 Divisor 0, dividend 0x1234, either mode -> quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0x1234, div_by_zero=1; done after edge E0+2.
REQ-032 Signed 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF -> quotient=0x8000_0000_0000_0000, remainder=0; the same operands unsigned -> quotient=0, remainder=0x8000_0000_0000_0000.
REQ-033 Start 50/5, pulse start with 9/3 at E0+10, rst_n=0 at E0+30 -> second start ignored; after reset all outputs 0, no done pulse; new 9/3 after reset -> quotient=3, remainder=0.
REQ-034 Randomized back-to-back operations (start pulsed in the cycle after done) -> REQ-023 identities hold for every result.

Source files
------------

// File: rtl/seq_divider_64.sv
// rtl/seq_divider_64.sv - sequential 64-bit restoring divider, signed/unsigned
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        synchronous active-low reset
//   start        request, sampled only in IDLE (ignored while done is high)
//   is_signed    1 = two's-complement divide, 0 = unsigned
//   dividend     numerator, captured with start
//   divisor      denominator, captured with start
//   busy         high from the accepting edge until done
//   done         single-cycle pulse, results valid
//   quotient     result quotient (held until the next FIX)
//   remainder    result remainder (held until the next FIX)
//   div_by_zero  divisor was zero (held with results)
module seq_divider_64 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIX    = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

    state_t           state;
    logic [5:0]       cnt;
    // a_reg shifts dividend bits out of the top while quotient bits enter at
    // the bottom; after the last iteration it holds the unsigned quotient.
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;
    logic             dz;

    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   diff;
    logic             fits;

    // Partial remainder can reach 65 bits; after a successful subtract the
    // result is always below the divisor, so it fits back in 64 bits.
    always_comb begin
        partial = {rem, a_reg[WIDTH-1]};
        diff    = partial - {1'b0, dvs};
        fits    = (partial >= {1'b0, dvs});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            a_reg       <= '0;
            rem         <= '0;
            dvs         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with the done pulse is not taken.
                    if (start && !done) begin
                        busy  <= 1'b1;
                        cnt   <= '0;
                        rem   <= '0;
                        neg_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r <= is_signed & dividend[WIDTH-1];
                        dvs   <= (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
                        if (divisor == '0) begin
                            // Keep the raw dividend: it is returned unmodified.
                            dz    <= 1'b1;
                            a_reg <= dividend;
                            state <= FIX;
                        end else begin
                            dz    <= 1'b0;
                            a_reg <= (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
                            state <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    rem   <= fits ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
                    a_reg <= {a_reg[WIDTH-2:0], fits};
                    cnt   <= cnt + 6'd1;
                    if (cnt == CNT_LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (dz) begin
                        quotient  <= '1;
                        remainder <= a_reg;
                    end else begin
                        quotient  <= neg_q ? -a_reg : a_reg;
                        remainder <= neg_r ? -rem : rem;
                    end
                    div_by_zero <= dz;
                    state       <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_64.sv
// tb/tb_seq_divider_64.sv - self-checking bench for seq_divider_64
module tb_seq_divider_64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        busy;
    logic        done;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_by_zero;

    int vecs = 0;
    int errs = 0;

    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    seq_divider_64 #(.WIDTH(64)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .is_signed(is_signed),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on the operands.
    task automatic model(input bit sg, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] q, output logic [63:0] r, output logic dz);
        longint sa;
        longint sb;
        sa = a;
        sb = b;
        dz = 1'b0;
        if (b == 64'd0) begin
            q  = ONES;
            r  = a;
            dz = 1'b1;
        end else if (!sg) begin
            q = a / b;
            r = a % b;
        end else if (a == MINV && b == ONES) begin
            q = MINV;
            r = 64'd0;
        end else begin
            q = 64'(sa / sb);
            r = 64'(sa % sb);
        end
    endtask

    function automatic logic [63:0] mag(input bit sg, input logic [63:0] v);
        return (sg && v[63]) ? -v : v;
    endfunction

    // Launch one operation from IDLE and check result, latency and busy width.
    task automatic run_op(input string tag, input bit sg, input logic [63:0] a,
                          input logic [63:0] b, input bit check_ident);
        logic [63:0] eq, er;
        logic        edz;
        int          n, nb, lat;
        model(sg, a, b, eq, er, edz);
        lat = edz ? 2 : 66;
        if (done) begin
            @(posedge clk); #1;
        end
        is_signed = sg;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk); #1;
        // Operand and start activity after acceptance must be ignored.
        dividend  = {$urandom, $urandom};
        divisor   = {$urandom, $urandom};
        is_signed = ~sg;
        n = 0;
        nb = 0;
        while (n < 200) begin
            if (busy) nb++;
            @(posedge clk); #1;
            n++;
            if (n == 1) start = 1'b0;
            if (done) break;
        end
        chk({tag, " latency"}, 64'(n), 64'(lat));
        chk({tag, " busy_cycles"}, 64'(nb), 64'(lat));
        chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(edz));
        if (check_ident && !edz) begin
            chk({tag, " ident_sum"}, quotient * b + remainder, a);
            chk({tag, " ident_mag"}, 64'(mag(sg, remainder) < mag(sg, b)), 64'd1);
            if (sg)
                chk({tag, " ident_sign"},
                    64'(remainder == 64'd0 || remainder[63] == a[63]), 64'd1);
        end
    endtask

    initial begin
        int pulses;
        logic [63:0] a, b;
        bit sg;
        rst_n = 1'b0;
        start = 1'b0;
        is_signed = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst quotient", quotient, 64'd0);
        chk("rst remainder", remainder, 64'd0);
        chk("rst div_by_zero", 64'(div_by_zero), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("u100/7", 1'b0, 64'd100, 64'd7, 1'b1);
        chk("u100/7 q14", quotient, 64'd14);
        chk("u100/7 r2", remainder, 64'd2);
        run_op("s-100/7", 1'b1, -64'd100, 64'd7, 1'b1);
        chk("s-100/7 q", quotient, 64'hFFFF_FFFF_FFFF_FFF2);
        chk("s-100/7 r", remainder, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("s100/-7", 1'b1, 64'd100, -64'd7, 1'b1);
        run_op("u1234/0", 1'b0, 64'h1234, 64'd0, 1'b0);
        run_op("s1234/0", 1'b1, 64'h1234, 64'd0, 1'b0);
        run_op("s_ovf", 1'b1, MINV, ONES, 1'b1);
        run_op("u_ovf_ops", 1'b0, MINV, ONES, 1'b1);

        // Results hold while idle.
        repeat (5) @(posedge clk);
        #1;
        chk("hold quotient", quotient, 64'd0);
        chk("hold remainder", remainder, MINV);

        // Start during the done cycle is ignored, accepted one cycle later.
        run_op("u77/5", 1'b0, 64'd77, 64'd5, 1'b1);
        start = 1'b1;
        is_signed = 1'b0;
        dividend = 64'd81;
        divisor = 64'd9;
        @(posedge clk); #1;
        chk("start_in_done ignored", 64'(busy), 64'd0);
        run_op("u81/9", 1'b0, 64'd81, 64'd9, 1'b1);

        // 50/5, second start mid-divide, reset (with start) mid-divide.
        if (done) begin
            @(posedge clk); #1;
        end
        is_signed = 1'b0;
        dividend = 64'd50;
        divisor = 64'd5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        dividend = 64'd9;
        divisor = 64'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("restart busy", 64'(busy), 64'd1);
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        start = 1'b0;
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst done", 64'(done), 64'd0);
        chk("midrst quotient", quotient, 64'd0);
        chk("midrst remainder", remainder, 64'd0);
        chk("midrst div_by_zero", 64'(div_by_zero), 64'd0);
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        chk("midrst no_done", 64'(pulses), 64'd0);
        run_op("u9/3", 1'b0, 64'd9, 64'd3, 1'b1);
        chk("u9/3 q", quotient, 64'd3);

        // Randomized back-to-back operations.
        for (int k = 0; k < 24; k++) begin
            sg = 1'($urandom);
            a = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: b = 64'($urandom_range(1, 20));
                1: b = -64'($urandom_range(1, 20));
                2: b = 64'd0;
                3: begin a = MINV; b = ONES; end
                4: b = {32'd0, $urandom};
                default: b = {$urandom, $urandom};
            endcase
            run_op("rand", sg, a, b, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
